nn_layer_writeback: RTL

Sequencer that drains one layer's activation outputs into the next stage after the layer's activation units finish. Drives the select of the 16:1 activation output multiplexer and takes back the selected 8-bit value, one neuron per cycle. Writes each value into the input FIFO for the next layer; on the final layer it writes to result memory instead. Stalls on FIFO full and reports completion to the layer controller.

---
 rtl/nn_layer_writeback.sv | 81 ++++++++
 1 files changed

// File: rtl/nn_layer_writeback.sv
// nn_layer_writeback: drains one layer's activations through the output mux into the next-layer FIFO or result memory
//   in : clk, reset_n (sync, active-low), start, n_active, last_layer, mem_base, mux_y, fifo_full
//   out: sel, fifo_wr_en/fifo_wdata, mem_we/mem_addr/mem_wdata, busy, done
module nn_layer_writeback #(
  parameter int DATA_W    = 8,
  parameter int N_NEURONS = 16,
  parameter int ADDR_W    = 8,
  localparam int SW       = $clog2(N_NEURONS),
  localparam int NW       = $clog2(N_NEURONS + 1)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [NW-1:0]     n_active,
  input  logic              last_layer,
  input  logic [ADDR_W-1:0] mem_base,
  output logic [SW-1:0]     sel,
  input  logic [DATA_W-1:0] mux_y,
  input  logic              fifo_full,
  output logic              fifo_wr_en,
  output logic [DATA_W-1:0] fifo_wdata,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              busy,
  output logic              done
);
  typedef enum logic [1:0] {IDLE, WRITE, FIN} state_t;
  state_t              state_q, state_d;
  logic [SW-1:0]       sel_q, sel_d;
  logic [NW-1:0]       n_q, n_d;
  logic                last_q, last_d;
  logic [ADDR_W-1:0]   base_q, base_d;
  logic                accept, last_sel;
  assign fifo_wr_en = (state_q == WRITE) && !last_q && !fifo_full;
  assign mem_we     = (state_q == WRITE) && last_q;
  assign accept     = fifo_wr_en || mem_we;
  assign last_sel   = NW'(sel_q) == n_q - NW'(1);
  assign sel        = sel_q;
  assign fifo_wdata = mux_y;
  assign mem_wdata  = mux_y;
  assign mem_addr   = base_q + ADDR_W'(sel_q);
  assign busy       = state_q != IDLE;
  assign done       = state_q == FIN;
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    n_d     = n_q;
    last_d  = last_q;
    base_d  = base_q;
    case (state_q)
      IDLE: if (start) begin
        state_d = (n_active == '0) ? FIN : WRITE;
        n_d     = (n_active > NW'(N_NEURONS)) ? NW'(N_NEURONS) : n_active;
        last_d  = last_layer;
        base_d  = mem_base;
        sel_d   = '0;
      end
      WRITE: if (accept) begin
        state_d = last_sel ? FIN : WRITE;
        sel_d   = last_sel ? '0 : sel_q + SW'(1);
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      sel_q   <= '0;
      n_q     <= '0;
      last_q  <= 1'b0;
      base_q  <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      n_q     <= n_d;
      last_q  <= last_d;
      base_q  <= base_d;
    end
  end
endmodule
